// File: rtl/chan_cfg_seq_pkg.sv
// rtl/chan_cfg_seq_pkg.sv - shared types and constants for the channelizer config sequencer
package chan_cfg_seq_pkg;

    // Default legal log2 FFT size range.
    localparam int DEF_MIN_LOG_FFT = 3;
    localparam int DEF_MAX_LOG_FFT = 11;

    // Cycles the FFT core is given out of reset before its config is sent.
    localparam int FFT_WAIT_CYCLES = 2;

    // Width of the log2 size code (covers log2 values up to 31).
    localparam int NFFT_WIDTH = 5;

    typedef enum logic [1:0] {
        S_RESET    = 2'd0,
        S_FFT_WAIT = 2'd1,
        S_CONFIG   = 2'd2,
        S_RUN      = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/pow2_log2_enc.sv
// rtl/pow2_log2_enc.sv - power-of-two legality check and log2 encoder for the FFT size
//
// Ports:
//   size  - requested FFT size (bins)
//   legal - size is a power of two with log2 in [MIN_LOG_FFT, MAX_LOG_FFT]
//   log2  - log2(size); only meaningful when size is a power of two
module pow2_log2_enc
    import chan_cfg_seq_pkg::*;
#(
    parameter int FFT_SIZE_WIDTH = 12,
    parameter int MIN_LOG_FFT    = DEF_MIN_LOG_FFT,
    parameter int MAX_LOG_FFT    = DEF_MAX_LOG_FFT
) (
    input  logic [FFT_SIZE_WIDTH-1:0] size,
    output logic                      legal,
    output logic [NFFT_WIDTH-1:0]     log2
);

    // At most one position can match exactly, so the loop acts as a
    // one-hot detector and encoder at the same time.
    always_comb begin
        legal = 1'b0;
        log2  = '0;
        for (int i = 0; i < FFT_SIZE_WIDTH; i++) begin
            if (size == (FFT_SIZE_WIDTH'(1) << i)) begin
                log2  = NFFT_WIDTH'(i);
                legal = (i >= MIN_LOG_FFT) && (i <= MAX_LOG_FFT);
            end
        end
    end

endmodule

// File: rtl/chan_cfg_seq.sv
// rtl/chan_cfg_seq.sv - configuration latch and reset/FFT-config sequencer for the channelizer
//
// Ports:
//   clk, aresetn                      - clock, asynchronous active-low reset
//   fft_size, payload_length, avg_len - requested runtime configuration
//   cfg_req                           - pulse forcing a full reconfiguration
//   fft_size_s, nfft, payload_length_m1, avg_len_s - latched configuration
//   core_reset                        - active-high datapath reset
//   fft_aresetn                       - FFT core reset, active-low
//   m_axis_config_*                   - FFT config stream (tdata = nfft)
//   cfg_done, cfg_err                 - running / sticky illegal-request status
module chan_cfg_seq
    import chan_cfg_seq_pkg::*;
#(
    parameter int MIN_LOG_FFT    = DEF_MIN_LOG_FFT,
    parameter int MAX_LOG_FFT    = DEF_MAX_LOG_FFT,
    parameter int FFT_SIZE_WIDTH = 12,
    parameter int PAYLOAD_WIDTH  = 16,
    parameter int AVG_WIDTH      = 9,
    parameter int CFG_WIDTH      = 16,
    parameter int RESET_HOLD     = 8
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
    input  logic [PAYLOAD_WIDTH-1:0]  payload_length,
    input  logic [AVG_WIDTH-1:0]      avg_len,
    input  logic                      cfg_req,
    output logic [FFT_SIZE_WIDTH-1:0] fft_size_s,
    output logic [NFFT_WIDTH-1:0]     nfft,
    output logic [PAYLOAD_WIDTH-1:0]  payload_length_m1,
    output logic [AVG_WIDTH-1:0]      avg_len_s,
    output logic                      core_reset,
    output logic                      fft_aresetn,
    output logic                      m_axis_config_tvalid,
    input  logic                      m_axis_config_tready,
    output logic [CFG_WIDTH-1:0]      m_axis_config_tdata,
    output logic                      cfg_done,
    output logic                      cfg_err
);

    localparam int                        CNT_W      = $clog2(RESET_HOLD);
    localparam logic [CNT_W-1:0]          HOLD_LOAD  = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0]          WAIT_LOAD  = CNT_W'(FFT_WAIT_CYCLES - 1);
    localparam logic [FFT_SIZE_WIDTH-1:0] RESET_SIZE = FFT_SIZE_WIDTH'(1) << MIN_LOG_FFT;

    // Input capture. These flops deliberately have no reset so they keep
    // sampling while aresetn is low; the values present at release are then
    // compared against the reset defaults on the very first edge.
    logic [FFT_SIZE_WIDTH-1:0] fft_size_in_q;
    logic [PAYLOAD_WIDTH-1:0]  payload_in_q;
    logic [AVG_WIDTH-1:0]      avg_in_q;
    logic                      cfg_req_in_q;

    always_ff @(posedge clk) begin
        fft_size_in_q <= fft_size;
        payload_in_q  <= payload_length;
        avg_in_q      <= avg_len;
        cfg_req_in_q  <= cfg_req;
    end

    logic                  size_legal;
    logic [NFFT_WIDTH-1:0] size_log2;

    pow2_log2_enc #(
        .FFT_SIZE_WIDTH (FFT_SIZE_WIDTH),
        .MIN_LOG_FFT    (MIN_LOG_FFT),
        .MAX_LOG_FFT    (MAX_LOG_FFT)
    ) u_size_enc (
        .size  (fft_size_in_q),
        .legal (size_legal),
        .log2  (size_log2)
    );

    cfg_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      pend_q, pend_d;
    logic [FFT_SIZE_WIDTH-1:0] fft_size_s_q, fft_size_s_d;
    logic [NFFT_WIDTH-1:0]     nfft_q, nfft_d;
    logic [PAYLOAD_WIDTH-1:0]  payload_s_q, payload_s_d;
    logic [PAYLOAD_WIDTH-1:0]  payload_m1_q, payload_m1_d;
    logic [AVG_WIDTH-1:0]      avg_s_q, avg_s_d;
    logic                      core_reset_q, core_reset_d;
    logic                      fft_aresetn_q, fft_aresetn_d;
    logic                      tvalid_q, tvalid_d;
    logic [CFG_WIDTH-1:0]      tdata_q, tdata_d;
    logic                      cfg_done_q, cfg_done_d;
    logic                      cfg_err_q, cfg_err_d;

    // Change classification. A cfg_req with illegal pending values still
    // restarts the sequence, but on the previously latched configuration.
    logic values_diff, legal_req, latch_en, reconf, illegal_req, handshake;

    assign values_diff = (fft_size_in_q != fft_size_s_q) ||
                         (payload_in_q  != payload_s_q)  ||
                         (avg_in_q      != avg_s_q);
    assign legal_req   = size_legal && (payload_in_q != '0);
    assign latch_en    = (values_diff || cfg_req_in_q) && legal_req;
    assign reconf      = latch_en || cfg_req_in_q;
    assign illegal_req = values_diff && !legal_req;
    assign handshake   = tvalid_q && m_axis_config_tready;

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_RESET;
            cnt_q   <= HOLD_LOAD;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic. In S_CONFIG a reconfiguration is only remembered;
    // the offered config beat must complete before the reset restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            S_RESET: begin
                if (reconf) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_FFT_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FFT_WAIT: begin
                if (reconf) begin
                    state_d = S_RESET;
                    cnt_d   = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_CONFIG;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CONFIG: begin
                if (handshake) begin
                    pend_d = 1'b0;
                    if (pend_q || reconf) begin
                        state_d = S_RESET;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (reconf) begin
                    pend_d = 1'b1;
                end
            end
            S_RUN: begin
                if (reconf) begin
                    state_d = S_RESET;
                    cnt_d   = HOLD_LOAD;
                end
            end
            default: begin
                state_d = S_RESET;
                cnt_d   = HOLD_LOAD;
            end
        endcase
    end

    // Output logic, decoded from the next state so every output is a flop.
    // tdata is captured only on entry to S_CONFIG so a latch of new values
    // during a stalled beat cannot disturb it.
    always_comb begin
        core_reset_d  = (state_d != S_RUN);
        fft_aresetn_d = (state_d != S_RESET);
        tvalid_d      = (state_d == S_CONFIG);
        cfg_done_d    = (state_d == S_RUN);
        tdata_d       = tdata_q;
        if ((state_d == S_CONFIG) && (state_q != S_CONFIG)) begin
            tdata_d = CFG_WIDTH'(nfft_q);
        end

        fft_size_s_d = fft_size_s_q;
        nfft_d       = nfft_q;
        payload_s_d  = payload_s_q;
        avg_s_d      = avg_s_q;
        if (latch_en) begin
            fft_size_s_d = fft_size_in_q;
            nfft_d       = size_log2;
            payload_s_d  = payload_in_q;
            avg_s_d      = avg_in_q;
        end
        payload_m1_d = payload_s_q - 1'b1;

        if (illegal_req) begin
            cfg_err_d = 1'b1;
        end else if (reconf) begin
            cfg_err_d = 1'b0;
        end else begin
            cfg_err_d = cfg_err_q;
        end
    end

    // Latched payload resets to 1 so payload_length_m1 resets to 0 consistently.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            core_reset_q  <= 1'b1;
            fft_aresetn_q <= 1'b0;
            tvalid_q      <= 1'b0;
            tdata_q       <= CFG_WIDTH'(MIN_LOG_FFT);
            cfg_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            fft_size_s_q  <= RESET_SIZE;
            nfft_q        <= NFFT_WIDTH'(MIN_LOG_FFT);
            payload_s_q   <= PAYLOAD_WIDTH'(1);
            payload_m1_q  <= '0;
            avg_s_q       <= '0;
        end else begin
            core_reset_q  <= core_reset_d;
            fft_aresetn_q <= fft_aresetn_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            cfg_done_q    <= cfg_done_d;
            cfg_err_q     <= cfg_err_d;
            fft_size_s_q  <= fft_size_s_d;
            nfft_q        <= nfft_d;
            payload_s_q   <= payload_s_d;
            payload_m1_q  <= payload_m1_d;
            avg_s_q       <= avg_s_d;
        end
    end

    assign fft_size_s           = fft_size_s_q;
    assign nfft                 = nfft_q;
    assign payload_length_m1    = payload_m1_q;
    assign avg_len_s            = avg_s_q;
    assign core_reset           = core_reset_q;
    assign fft_aresetn          = fft_aresetn_q;
    assign m_axis_config_tvalid = tvalid_q;
    assign m_axis_config_tdata  = tdata_q;
    assign cfg_done             = cfg_done_q;
    assign cfg_err              = cfg_err_q;

endmodule
